// File: rtl/sid_voice_sched_pkg.sv
// Shared types for the SID voice scheduler: slot/result types, voice state
// payload, chip model, scheduler states and the per-model DC offset.
package sid;

    localparam int unsigned NUM_SLOTS = 6;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned WAV_W     = 12;
    localparam int unsigned ENV_W     = 8;
    localparam int unsigned DCA_W     = 14;
    localparam int unsigned RES_W     = 24;

    typedef logic [SLOT_W-1:0]       slot_t;
    typedef logic [7:0]              reg8_t;
    typedef logic signed [RES_W-1:0] s24_t;
    typedef logic signed [DCA_W-1:0] dca_t;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic noise_en;
        logic pulse_en;
        logic saw_en;
        logic tri_en;
    } wave_sel_t;

    typedef struct packed {
        wave_sel_t         wave;
        logic [WAV_W-1:0]  saw_tri;
        logic [WAV_W-1:0]  pw;
        logic [7:0]        noise;
        logic [ENV_W-1:0]  env;
    } voice_i_t;

    // The 6581 DAC idles well above mid-scale; the 8580 is nearly centred.
    function automatic dca_t dc_offset(input model_e model);
        return (model == MOS6581) ? 14'sd896 : 14'sd16;
    endfunction

endpackage

// File: rtl/sid_voice_sched_if.sv
// Frame-control and voice-lookup bus between the scheduler and its host.
interface sid_voice_sched_if #(
    parameter int unsigned NUM_SLOTS = sid::NUM_SLOTS
) ();

    logic          tick_i;
    sid::model_e   model_i [2];
    sid::slot_t    slot_o;
    sid::voice_i_t voice_i;
    sid::s24_t     voice_o [NUM_SLOTS];
    sid::reg8_t    osc3_o  [2];
    logic          done_o;
    logic          busy_o;
    logic          overrun_o;

    modport master (
        output tick_i, model_i, voice_i,
        input  slot_o, voice_o, osc3_o, done_o, busy_o, overrun_o
    );

    modport slave (
        input  tick_i, model_i, voice_i,
        output slot_o, voice_o, osc3_o, done_o, busy_o, overrun_o
    );

endinterface

// File: rtl/sid_voice.sv
// Shared waveform + DCA datapath: one voice per cycle in, result LATENCY
// cycles later. Mixed waveforms combine by AND as on the real chip.
module sid_voice #(
    parameter int unsigned LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  sid::voice_i_t voice_i,
    input  sid::model_e   model_i,
    output sid::s24_t     voice_o,
    output sid::reg8_t    osc_o
);
    import sid::*;

    logic [WAV_W-1:0] tri_c;
    logic [WAV_W-1:0] pulse_c;
    logic [WAV_W-1:0] wav_c;
    logic             silent_c;
    dca_t             wave_s_c;
    dca_t             dca_s_c;
    s24_t             prod_c;

    s24_t  voice_pipe_q [LATENCY];
    s24_t  voice_pipe_d [LATENCY];
    reg8_t osc_pipe_q   [LATENCY];
    reg8_t osc_pipe_d   [LATENCY];

    // Waveform select, centring and envelope scaling.
    always_comb begin
        tri_c    = voice_i.saw_tri[WAV_W-1] ? ~{voice_i.saw_tri[WAV_W-2:0], 1'b0}
                                            :  {voice_i.saw_tri[WAV_W-2:0], 1'b0};
        pulse_c  = (voice_i.saw_tri >= voice_i.pw) ? 12'hFFF : 12'h000;
        silent_c = (voice_i.wave == 4'b0000);
        wav_c    = 12'hFFF;
        if (voice_i.wave.tri_en)   wav_c = wav_c & tri_c;
        if (voice_i.wave.saw_en)   wav_c = wav_c & voice_i.saw_tri;
        if (voice_i.wave.pulse_en) wav_c = wav_c & pulse_c;
        if (voice_i.wave.noise_en) wav_c = wav_c & {voice_i.noise, 4'h0};
        if (silent_c)              wav_c = 12'h000;
        // A silent voice leaves the DAC at zero; only the DC offset remains.
        wave_s_c = silent_c ? 14'sd0 : ($signed({2'b00, wav_c}) - 14'sd2048);
        dca_s_c  = wave_s_c + dc_offset(model_i);
        prod_c   = 24'(dca_s_c) * $signed({16'h0000, voice_i.env});
    end

    always_comb begin
        voice_pipe_d[0] = prod_c;
        osc_pipe_d[0]   = wav_c[WAV_W-1:WAV_W-8];
        for (int i = 1; i < int'(LATENCY); i++) begin
            voice_pipe_d[i] = voice_pipe_q[i-1];
            osc_pipe_d[i]   = osc_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voice_pipe_q <= '{default: '0};
            osc_pipe_q   <= '{default: '0};
        end else begin
            voice_pipe_q <= voice_pipe_d;
            osc_pipe_q   <= osc_pipe_d;
        end
    end

    assign voice_o = voice_pipe_q[LATENCY-1];
    assign osc_o   = osc_pipe_q[LATENCY-1];

endmodule

// File: rtl/sid_voice_sched.sv
// Per-frame voice scheduler: walks every voice slot through the shared
// sid_voice datapath once per tick and latches the per-slot results.
module sid_voice_sched #(
    parameter int unsigned NUM_SLOTS = sid::NUM_SLOTS,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    sid_voice_sched_if.slave    bus
);
    import sid::*;

    localparam int unsigned CNT_W      = 8;
    localparam slot_t       LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LATENCY - 1);

    sched_state_e     state_q, state_d;
    slot_t            slot_q, slot_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic             issue_c;
    logic             chip_c;
    model_e           model_c;

    logic             tag_vld_q [LATENCY];
    logic             tag_vld_d [LATENCY];
    slot_t            tag_q     [LATENCY];
    slot_t            tag_d     [LATENCY];

    s24_t             voice_q [NUM_SLOTS];
    s24_t             voice_d [NUM_SLOTS];
    reg8_t            osc3_q  [2];
    reg8_t            osc3_d  [2];

    s24_t             dp_voice;
    reg8_t            dp_osc;

    // Frame sequencing; ticks that land mid-frame only raise the sticky flag.
    always_comb begin
        state_d   = state_q;
        slot_d    = '0;
        drain_d   = '0;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tick_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.tick_i) overrun_d = 1'b1;
                if (slot_q == LAST_SLOT) state_d = DRAIN;
                else                     slot_d  = slot_q + SLOT_W'(1);
            end
            DRAIN: begin
                if (bus.tick_i) overrun_d = 1'b1;
                if (drain_q == LAST_DRAIN) state_d = DONE;
                else                       drain_d = drain_q + CNT_W'(1);
            end
            DONE: begin
                state_d = bus.tick_i ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    assign issue_c = (state_q == ISSUE);
    assign chip_c  = (slot_q >= SLOT_W'(3));
    assign model_c = bus.model_i[chip_c];

    sid_voice #(
        .LATENCY (LATENCY)
    ) u_voice (
        .clk     (clk),
        .rst     (rst),
        .voice_i (bus.voice_i),
        .model_i (model_c),
        .voice_o (dp_voice),
        .osc_o   (dp_osc)
    );

    // Slot tag travels alongside the datapath so results land in the right slot.
    always_comb begin
        tag_vld_d[0] = issue_c;
        tag_d[0]     = slot_q;
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_d[i]     = tag_q[i-1];
        end
    end

    always_comb begin
        voice_d = voice_q;
        osc3_d  = osc3_q;
        if (tag_vld_q[LATENCY-1]) begin
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                if (tag_q[LATENCY-1] == SLOT_W'(k)) voice_d[k] = dp_voice;
            end
            if (tag_q[LATENCY-1] == SLOT_W'(2)) osc3_d[0] = dp_osc;
            if (tag_q[LATENCY-1] == SLOT_W'(5)) osc3_d[1] = dp_osc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            tag_vld_q <= '{default: 1'b0};
            tag_q     <= '{default: '0};
            voice_q   <= '{default: '0};
            osc3_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            voice_q   <= voice_d;
            osc3_q    <= osc3_d;
        end
    end

    assign bus.slot_o    = slot_q;
    assign bus.voice_o   = voice_q;
    assign bus.osc3_o    = osc3_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_sid_voice_sched.sv
// Scoreboard bench for sid_voice_sched: frame expectations are queued at each
// accepted tick and checked by a monitor whenever done_o pulses.
module tb_sid_voice_sched;

    localparam logic [3:0] WF_NONE  = 4'b0000;
    localparam logic [3:0] WF_NOISE = 4'b1000;
    localparam logic [3:0] WF_PULSE = 4'b0100;
    localparam logic [3:0] WF_SAW   = 4'b0010;
    localparam logic [3:0] WF_TRI   = 4'b0001;

    typedef struct {
        sid::s24_t  v [6];
        sid::reg8_t o [2];
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vset   = 0;
    logic ovr_exp = 1'b0;

    sid::voice_i_t vtbl [2][6];
    exp_t          exp_tbl [3];
    exp_t          sb_q [$];

    sid_voice_sched_if bus ();

    sid_voice_sched #(
        .NUM_SLOTS (6),
        .LATENCY   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Upstream voice-state store: answers slot_o combinationally.
    always_comb begin
        if (bus.slot_o < 3'd6) bus.voice_i = vtbl[vset][bus.slot_o];
        else                   bus.voice_i = '0;
    end

    function automatic sid::voice_i_t mk(input logic [3:0] wf, input logic [11:0] st,
                                         input logic [11:0] pw, input logic [7:0] nz,
                                         input logic [7:0] env);
        sid::voice_i_t v;
        v.wave    = wf;
        v.saw_tri = st;
        v.pw      = pw;
        v.noise   = nz;
        v.env     = env;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},    64'(bus.busy_o),    0);
        chk({tag, "_done"},    64'(bus.done_o),    0);
        chk({tag, "_slot"},    64'(bus.slot_o),    0);
        chk({tag, "_overrun"}, 64'(bus.overrun_o), 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s_voice%0d", tag, k), 64'(bus.voice_o[k]), 0);
        for (int c = 0; c < 2; c++)
            chk($sformatf("%s_osc3_%0d", tag, c), 64'(bus.osc3_o[c]), 0);
    endtask

    task automatic start_frame(input int set, input int case_id, input bit expect_done);
        vset = set;
        if (expect_done) sb_q.push_back(exp_tbl[case_id]);
        bus.tick_i = 1'b1;
    endtask

    // Walks cycles 1..8 of a frame started in the current cycle.
    task automatic follow_frame(input bit chain, input int next_set, input int next_case,
                                input int ovr_at, input int chg_at);
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.tick_i = 1'b0;
            if (ovr_at != 0 && c == ovr_at + 1) ovr_exp = 1'b1;
            chk($sformatf("slot_c%0d", c), 64'(bus.slot_o), (c <= 6) ? c - 1 : 0);
            chk($sformatf("busy_c%0d", c), 64'(bus.busy_o), (c <= 7) ? 1 : 0);
            chk($sformatf("done_c%0d", c), 64'(bus.done_o), (c == 8) ? 1 : 0);
            chk($sformatf("overrun_c%0d", c), 64'(bus.overrun_o), 64'(ovr_exp));
            if (c == ovr_at) bus.tick_i = 1'b1;
            if (c == chg_at) bus.model_i[1] = sid::MOS6581;
            if (c == 8 && chain) start_frame(next_set, next_case, 1'b1);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest queued frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o 1, expected no frame (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < 6; k++)
                        chk($sformatf("sb_voice%0d", k), 64'(bus.voice_o[k]), 64'(e.v[k]));
                    for (int c = 0; c < 2; c++)
                        chk($sformatf("sb_osc3_%0d", c), 64'(bus.osc3_o[c]), 64'(e.o[c]));
                end
            end
        end
    end

    initial begin
        vtbl[0][0] = mk(WF_NONE,  12'h000, 12'h000, 8'h00, 8'hFF);
        vtbl[0][1] = mk(WF_SAW,   12'h800, 12'h000, 8'h00, 8'h10);
        vtbl[0][2] = mk(WF_SAW,   12'hABC, 12'h000, 8'h00, 8'h01);
        vtbl[0][3] = mk(WF_NONE,  12'h000, 12'h000, 8'h00, 8'hFF);
        vtbl[0][4] = mk(WF_PULSE, 12'h100, 12'h200, 8'h00, 8'h02);
        vtbl[0][5] = mk(WF_SAW,   12'hABC, 12'h000, 8'h00, 8'h01);
        vtbl[1][0] = mk(WF_TRI,   12'h900, 12'h000, 8'h00, 8'h04);
        vtbl[1][1] = mk(WF_NOISE, 12'h000, 12'h000, 8'h5A, 8'h01);
        vtbl[1][2] = mk(WF_SAW | WF_TRI, 12'h400, 12'h000, 8'h00, 8'h01);
        vtbl[1][3] = mk(WF_PULSE, 12'h300, 12'h200, 8'h00, 8'h03);
        vtbl[1][4] = mk(WF_NONE,  12'h000, 12'h000, 8'h00, 8'h00);
        vtbl[1][5] = mk(WF_SAW,   12'hFFF, 12'h000, 8'h00, 8'hFF);

        // Set 0, chip0 6581 (DC 896), chip1 8580 (DC 16).
        exp_tbl[0].v = '{24'sd228480, 24'sd14336, 24'sd1596, 24'sd4080, -24'sd4064, 24'sd716};
        exp_tbl[0].o = '{8'hAB, 8'hAB};
        // Set 1, same models.
        exp_tbl[1].v = '{24'sd9724, 24'sd288, -24'sd1152, 24'sd6189, 24'sd0, 24'sd526065};
        exp_tbl[1].o = '{8'h00, 8'hFF};
        // Set 0, chip1 switched to 6581 after slot 3 has been issued.
        exp_tbl[2].v = '{24'sd228480, 24'sd14336, 24'sd1596, 24'sd4080, -24'sd2304, 24'sd1596};
        exp_tbl[2].o = '{8'hAB, 8'hAB};

        rst            = 1'b1;
        bus.tick_i     = 1'b0;
        bus.model_i[0] = sid::MOS6581;
        bus.model_i[1] = sid::MOS8580;
        repeat (2) step();
        rst = 1'b0;
        check_cleared("reset");

        // Single frame chained back-to-back into a second frame.
        start_frame(0, 0, 1'b1);
        follow_frame(1'b1, 1, 1, 0, 0);
        follow_frame(1'b0, 0, 0, 0, 0);
        step();
        chk("idle_busy",    64'(bus.busy_o),    0);
        chk("idle_slot",    64'(bus.slot_o),    0);
        chk("idle_overrun", 64'(bus.overrun_o), 0);

        // Dropped tick at cycle 3 plus a chip-1 model change mid-frame.
        start_frame(0, 2, 1'b1);
        follow_frame(1'b0, 0, 0, 3, 5);
        step();
        chk("ovr_sticky_idle", 64'(bus.overrun_o), 1);
        bus.model_i[1] = sid::MOS8580;

        // Reset during ISSUE: no capture and no done pulse afterwards.
        start_frame(0, 0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            bus.tick_i = 1'b0;
            chk($sformatf("ovr_hold_c%0d", c), 64'(bus.overrun_o), 1);
            if (c == 4) rst = 1'b1;
        end
        step();
        rst     = 1'b0;
        ovr_exp = 1'b0;
        check_cleared("midrst");
        for (int c = 0; c < 12; c++) begin
            step();
            chk("post_rst_done", 64'(bus.done_o), 0);
            chk("post_rst_busy", 64'(bus.busy_o), 0);
        end
        chk("sb_drained", 64'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
